// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : Fetch-stage PC sequencer feeding the icache and the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter int                 PC_SIZE    = 32,
    parameter int                 INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC   = '0,
    parameter int                 CNT_SIZE   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_SIZE-1:0]    pc,
    input  logic [INSTR_SIZE-1:0] inst_fu,
    input  logic                  cache_miss,
    input  logic                  stall_id,
    input  logic                  branch_taken,
    input  logic [PC_SIZE-1:0]    branch_target,
    output logic [INSTR_SIZE-1:0] instr_id,
    output logic [PC_SIZE-1:0]    pc_id,
    output logic                  valid_id,
    output logic                  target_misaligned,
    output logic [CNT_SIZE-1:0]   miss_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MISS       = 2'd1,
        ST_MISS_REDIR = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PC_SIZE-1:0]      r_redir_pc;
    logic [PC_SIZE-1:0]      w_redir_pc_nxt;
    logic [PC_SIZE-1:0]      w_pc_nxt;
    logic [PC_SIZE-1:0]      w_pc_id_nxt;
    logic [INSTR_SIZE-1:0]   w_instr_id_nxt;
    logic                    w_valid_nxt;
    logic                    w_tmis_nxt;
    logic [CNT_SIZE-1:0]     w_cnt_nxt;
    logic [CNT_SIZE-1:0]     w_cnt_inc;
    logic [PC_SIZE-1:0]      w_target;
    logic                    w_load;

    assign w_target  = {branch_target[PC_SIZE-1:2], 2'b00};
    assign w_cnt_inc = (miss_count == {CNT_SIZE{1'b1}}) ? miss_count
                                                        : miss_count + CNT_SIZE'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_redir_pc_nxt = r_redir_pc;
        w_pc_nxt       = pc;
        w_pc_id_nxt    = pc_id;
        w_instr_id_nxt = instr_id;
        w_valid_nxt    = valid_id;
        w_tmis_nxt     = target_misaligned;
        w_cnt_nxt      = miss_count;
        w_load         = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    w_valid_nxt = 1'b0;
                    w_tmis_nxt  = |branch_target[1:0];
                    if (cache_miss) begin
                        // pc is the refill address, so the redirect waits
                        w_redir_pc_nxt = w_target;
                        w_cnt_nxt      = w_cnt_inc;
                        w_state_nxt    = ST_MISS_REDIR;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end else if (cache_miss) begin
                    w_state_nxt = ST_MISS;
                    w_cnt_nxt   = w_cnt_inc;
                    if (!stall_id) w_valid_nxt = 1'b0;
                end else if (!stall_id) begin
                    w_load = 1'b1;
                end
            end
            ST_MISS: begin
                if (branch_taken) begin
                    w_redir_pc_nxt = w_target;
                    w_valid_nxt    = 1'b0;
                    w_tmis_nxt     = |branch_target[1:0];
                    w_state_nxt    = ST_MISS_REDIR;
                end else if (!cache_miss) begin
                    w_state_nxt = ST_RUN;
                    if (!stall_id) w_load = 1'b1;
                end else if (!stall_id) begin
                    w_valid_nxt = 1'b0;
                end
            end
            ST_MISS_REDIR: begin
                w_valid_nxt = 1'b0;
                if (branch_taken) begin
                    w_redir_pc_nxt = w_target;
                    w_tmis_nxt     = |branch_target[1:0];
                end
                if (!cache_miss) begin
                    // youngest redirect wins, including one arriving this cycle
                    w_pc_nxt    = branch_taken ? w_target : r_redir_pc;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (w_load) begin
            w_instr_id_nxt = inst_fu;
            w_pc_id_nxt    = pc;
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = pc + PC_SIZE'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= RESET_PC;
            r_redir_pc        <= '0;
            instr_id          <= '0;
            pc_id             <= '0;
            valid_id          <= 1'b0;
            target_misaligned <= 1'b0;
            miss_count        <= '0;
        end else begin
            pc                <= w_pc_nxt;
            r_redir_pc        <= w_redir_pc_nxt;
            instr_id          <= w_instr_id_nxt;
            pc_id             <= w_pc_id_nxt;
            valid_id          <= w_valid_nxt;
            target_misaligned <= w_tmis_nxt;
            miss_count        <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
